// File: rtl/lr35902_ppu_pkg.sv
// Shared types and constants for the LR35902 PPU pixel pipe.
// Fetch states, source tags, VRAM bases and address helpers.
package lr35902_ppu_pkg;

  typedef enum logic [2:0] {
    F_IDLE,
    F_TILE_0,
    F_TILE_1,
    F_PXL0_0,
    F_PXL0_1,
    F_PXL1_0,
    F_PXL1_1,
    F_PUSH
  } fetch_st_e;

  localparam logic [1:0] SRC_BG = 2'd0;
  localparam logic [1:0] SRC_WD = 2'd1;
  localparam logic [1:0] SRC_O0 = 2'd2;
  localparam logic [1:0] SRC_O1 = 2'd3;

  localparam logic [12:0] MAP_BASE_0 = 13'h1800;
  localparam logic [12:0] MAP_BASE_1 = 13'h1C00;
  localparam logic [12:0] TILE_BASE  = 13'h1000;

  localparam logic [7:0] SCREEN_W = 8'd160;

  function automatic logic [12:0] map_adr(
    input logic       sel,
    input logic [4:0] row,
    input logic [4:0] col
  );
    return (sel ? MAP_BASE_1 : MAP_BASE_0) + {3'd0, row, col};
  endfunction

  // Signed mode: 0x1000 + 16*signed(tile), wrapping in 13 bits.
  function automatic logic [12:0] tile_row_adr(
    input logic [7:0] tile,
    input logic       unsig,
    input logic [2:0] row,
    input logic       plane
  );
    logic [12:0] base;
    base = unsig ? {1'b0, tile, 4'h0}
                 : TILE_BASE + {tile[7], tile, 4'h0};
    return base + {9'd0, row, plane};
  endfunction

endpackage

// File: rtl/lr35902_ppu_pxfifo.sv
// Pixel shift FIFO: lo/hi plane bits plus source tag per entry.
// Ports: i_push (8 px, MSB first), i_pop (1 px), i_flush, o_level; head = o_lo/o_hi/o_src.
module lr35902_ppu_pxfifo #(
  parameter int DEPTH = 16,
  parameter int SRC_W = 2,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [7:0]       i_lo,
  input  logic [7:0]       i_hi,
  input  logic [SRC_W-1:0] i_src,
  input  logic             i_pop,
  output logic             o_lo,
  output logic             o_hi,
  output logic [SRC_W-1:0] o_src,
  output logic [LW-1:0]    o_level
);

  logic [DEPTH-1:0] r_lo;
  logic [DEPTH-1:0] r_hi;
  logic [SRC_W-1:0] r_src [DEPTH];
  logic [LW-1:0]    r_level;

  logic [DEPTH-1:0] w_lo;
  logic [DEPTH-1:0] w_hi;
  logic [SRC_W-1:0] w_src [DEPTH];
  logic [LW-1:0]    w_level;
  logic [LW-1:0]    w_base;

  // Entry 0 is the oldest pixel; a pop shifts all entries down.
  always_comb begin
    w_lo    = r_lo;
    w_hi    = r_hi;
    w_src   = r_src;
    w_base  = r_level;
    w_level = r_level;
    if (i_pop) begin
      w_lo = {1'b0, r_lo[DEPTH-1:1]};
      w_hi = {1'b0, r_hi[DEPTH-1:1]};
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_src[i] = r_src[i+1];
      end
      w_src[DEPTH-1] = '0;
      w_base = r_level - LW'(1);
    end
    w_level = w_base;
    if (i_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i >= int'(w_base) && i < int'(w_base) + 8) begin
          w_lo[i]  = i_lo[3'(7 - (i - int'(w_base)))];
          w_hi[i]  = i_hi[3'(7 - (i - int'(w_base)))];
          w_src[i] = i_src;
        end
      end
      w_level = w_base + LW'(8);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lo    <= '0;
      r_hi    <= '0;
      r_src   <= '{default: '0};
      r_level <= '0;
    end else if (i_flush) begin
      r_level <= '0;
    end else begin
      r_lo    <= w_lo;
      r_hi    <= w_hi;
      r_src   <= w_src;
      r_level <= w_level;
    end
  end

  assign o_lo    = r_lo[0];
  assign o_hi    = r_hi[0];
  assign o_src   = r_src[0];
  assign o_level = r_level;

endmodule

// File: rtl/lr35902_ppu_pixel_pipe.sv
// LR35902 PPU background/window fetcher, pixel FIFO and BGP mapping.
// Ports: line_start/regs/LCDC in; vram_adr/read/data; px_out/px/px_src, line_done, fifo_level.
// Window support is built only with PPU_WINDOW_EN defined.
module lr35902_ppu_pixel_pipe
  import lr35902_ppu_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SRC_W = 2,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line_start,
  input  logic [7:0]       ly,
  input  logic [7:0]       scx,
  input  logic [7:0]       scy,
  input  logic [7:0]       wx,
  input  logic [7:0]       wy,
  input  logic [7:0]       bgp,
  input  logic             bg_map,
  input  logic             bg_tiles,
  input  logic             bg_ena,
  input  logic             win_map,
  input  logic             win_ena,
  output logic [12:0]      vram_adr,
  output logic             vram_read,
  input  logic [7:0]       vram_data,
  output logic             px_out,
  output logic [1:0]       px,
  output logic [SRC_W-1:0] px_src,
  output logic             line_done,
  output logic [LW-1:0]    fifo_level
);

  fetch_st_e r_st;
  fetch_st_e w_st_nxt;

  logic [7:0] r_tile;
  logic [7:0] r_lo;
  logic [7:0] r_hi;
  logic [7:0] r_x;
  logic [4:0] r_tile_x;
  logic [2:0] r_disc;
  logic       r_active;
  logic       r_done;

  logic [LW-1:0]    w_level;
  logic             w_flo;
  logic             w_fhi;
  logic [SRC_W-1:0] w_fsrc;
  logic             w_shift;
  logic             w_visible;
  logic             w_done;
  logic             w_push_ok;
  logic             w_push;
  logic             w_flush;
  logic             w_trig;
  logic [7:0]       w_bg_y;
  logic [4:0]       w_bg_col;
  logic [12:0]      w_map_adr;
  logic [2:0]       w_row;
  logic [SRC_W-1:0] w_push_src;
  logic [1:0]       w_idx;

  assign w_bg_y   = ly + scy;
  assign w_bg_col = scx[7:3] + r_tile_x;

`ifdef PPU_WINDOW_EN
  logic       r_win_mode;
  logic       r_win_hit;
  logic [7:0] r_win_line;

  assign w_trig = r_active && !line_start && win_ena
               && (ly >= wy) && !r_win_hit
               && ((wx < 8'd7) ? (r_x == 8'd0)
                               : (r_x + 8'd7 == wx));

  assign w_map_adr = r_win_mode
    ? map_adr(win_map, r_win_line[7:3], r_tile_x)
    : map_adr(bg_map, w_bg_y[7:3], w_bg_col);
  assign w_row = r_win_mode ? r_win_line[2:0] : w_bg_y[2:0];
  assign w_push_src = r_win_mode ? SRC_W'(SRC_WD)
                                 : SRC_W'(SRC_BG);
  assign px_src = w_visible ? w_fsrc : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win_mode <= 1'b0;
      r_win_hit  <= 1'b0;
      r_win_line <= '0;
    end else if (line_start) begin
      r_win_mode <= 1'b0;
      r_win_hit  <= 1'b0;
      if (ly == 8'd0) r_win_line <= '0;
    end else if (w_done) begin
      r_win_mode <= 1'b0;
      if (r_win_hit) r_win_line <= r_win_line + 8'd1;
    end else if (w_trig) begin
      r_win_mode <= 1'b1;
      r_win_hit  <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_unused   = ^{win_map, win_ena, wx, wy, w_fsrc};
  assign w_trig     = 1'b0;
  assign w_map_adr  = map_adr(bg_map, w_bg_y[7:3], w_bg_col);
  assign w_row      = w_bg_y[2:0];
  assign w_push_src = SRC_W'(SRC_BG);
  assign px_src     = '0;
`endif

  // No shift while the line is (re)started or the window takes over.
  assign w_shift   = r_active && !line_start && !w_trig
                  && (w_level > LW'(8));
  assign w_visible = w_shift && (r_disc == 3'd0);
  assign w_done    = w_visible && (r_x == SCREEN_W - 8'd1);
  assign w_flush   = line_start || w_done || w_trig;
  assign w_push_ok = w_level <= LW'(FIFO_DEPTH - 8);
  assign w_push    = (r_st == F_PUSH) && w_push_ok && !w_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_st <= F_IDLE;
    else       r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt  = r_st;
    vram_read = 1'b0;
    vram_adr  = '0;
    unique case (r_st)
      F_IDLE: w_st_nxt = F_IDLE;
      F_TILE_0: begin
        vram_read = 1'b1;
        vram_adr  = w_map_adr;
        w_st_nxt  = F_TILE_1;
      end
      F_TILE_1: w_st_nxt = F_PXL0_0;
      F_PXL0_0: begin
        vram_read = 1'b1;
        vram_adr  = tile_row_adr(r_tile, bg_tiles, w_row, 1'b0);
        w_st_nxt  = F_PXL0_1;
      end
      F_PXL0_1: w_st_nxt = F_PXL1_0;
      F_PXL1_0: begin
        vram_read = 1'b1;
        vram_adr  = tile_row_adr(r_tile, bg_tiles, w_row, 1'b1);
        w_st_nxt  = F_PXL1_1;
      end
      F_PXL1_1: w_st_nxt = F_PUSH;
      F_PUSH:   if (w_push_ok) w_st_nxt = F_TILE_0;
      default:  w_st_nxt = F_IDLE;
    endcase
    if (line_start || w_trig) w_st_nxt = F_TILE_0;
    else if (w_done)          w_st_nxt = F_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tile   <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_x      <= '0;
      r_tile_x <= '0;
      r_disc   <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done;
      if (r_st == F_TILE_1) r_tile <= vram_data;
      if (r_st == F_PXL0_1) r_lo   <= vram_data;
      if (r_st == F_PXL1_1) r_hi   <= vram_data;
      if (line_start) begin
        r_active <= 1'b1;
        r_x      <= '0;
        r_tile_x <= '0;
        r_disc   <= scx[2:0];
      end else begin
        if (w_done) begin
          r_active <= 1'b0;
          r_tile_x <= '0;
        end else if (w_trig) begin
          r_tile_x <= '0;
          r_disc   <= '0;
        end else if (w_push) begin
          r_tile_x <= r_tile_x + 5'd1;
        end
        if (w_shift) begin
          if (r_disc != 3'd0) r_disc <= r_disc - 3'd1;
          else                r_x    <= r_x + 8'd1;
        end
      end
    end
  end

  lr35902_ppu_pxfifo #(
    .DEPTH (FIFO_DEPTH),
    .SRC_W (SRC_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_lo    (r_lo),
    .i_hi    (r_hi),
    .i_src   (w_push_src),
    .i_pop   (w_shift),
    .o_lo    (w_flo),
    .o_hi    (w_fhi),
    .o_src   (w_fsrc),
    .o_level (w_level)
  );

  assign w_idx      = bg_ena ? {w_fhi, w_flo} : 2'd0;
  assign px_out     = w_visible;
  assign px         = w_visible ? bgp[{w_idx, 1'b0} +: 2] : 2'd0;
  assign line_done  = r_done;
  assign fifo_level = w_level;

endmodule

// File: tb/tb_lr35902_ppu_pixel_pipe.sv
// Bench for lr35902_ppu_pixel_pipe: VRAM model, pixel scoreboard
// fed from a reference model, timing and address checks.
module tb_lr35902_ppu_pixel_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [7:0]  ly = 8'd0, scx = 8'd0, scy = 8'd0;
  logic [7:0]  wx = 8'd0, wy = 8'd0, bgp = 8'hE4;
  logic        bg_map = 1'b0, bg_tiles = 1'b1, bg_ena = 1'b1;
  logic        win_map = 1'b0, win_ena = 1'b0;
  logic [12:0] vram_adr;
  logic        vram_read;
  logic [7:0]  vram_data = 8'h00;
  logic        px_out;
  logic [1:0]  px;
  logic [1:0]  px_src;
  logic        line_done;
  logic [4:0]  fifo_level;

  logic [7:0] mem [8192];
  logic [3:0] sb [$];
  logic [3:0] e;

  int pass_n = 0, chk_n = 0;
  int cyc = 0, t0 = 0;
  int first_px, last_px, done_rel, npix, ndone;
  int lvl1, lvl8, lvl15, lvlw, r79, win_rd;
  int adr1, adr3, adr5;
  int noisy = 0, win_line_m = 0;
  bit quiet = 1'b0;

  lr35902_ppu_pixel_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .ly         (ly),
    .scx        (scx),
    .scy        (scy),
    .wx         (wx),
    .wy         (wy),
    .bgp        (bgp),
    .bg_map     (bg_map),
    .bg_tiles   (bg_tiles),
    .bg_ena     (bg_ena),
    .win_map    (win_map),
    .win_ena    (win_ena),
    .vram_adr   (vram_adr),
    .vram_read  (vram_read),
    .vram_data  (vram_data),
    .px_out     (px_out),
    .px         (px),
    .px_src     (px_src),
    .line_done  (line_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (vram_read) vram_data <= mem[vram_adr];

  task automatic check(string tag, int got, int exp);
    chk_n++;
    if (got == exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: screen pixel x of the current line -> {src, colour}.
  function automatic logic [3:0] model(int x);
    int bx, by, ma, t, ta, bi, idx;
    logic [7:0] lo, hi;
    bit win;
    win = 1'b0;
`ifdef PPU_WINDOW_EN
    if (win_ena && ly >= wy && (wx < 7 || x >= wx - 7)) win = 1'b1;
`endif
    if (win) begin
      bx = (wx < 7) ? x : x - (wx - 7);
      by = win_line_m;
      ma = (win_map ? 'h1C00 : 'h1800) + 32 * (by >> 3) + ((bx >> 3) & 31);
    end else begin
      bx = (scx + x) & 255;
      by = (ly + scy) & 255;
      ma = (bg_map ? 'h1C00 : 'h1800) + 32 * (by >> 3) + (bx >> 3);
    end
    t  = mem[ma];
    ta = bg_tiles ? 16 * t : 4096 + 16 * ((t >= 128) ? t - 256 : t);
    ta = (ta + 2 * (by & 7)) & 'h1FFF;
    lo = mem[ta];
    hi = mem[(ta + 1) & 'h1FFF];
    bi = 7 - (bx & 7);
    idx = bg_ena ? ((int'(hi[bi]) << 1) | int'(lo[bi])) : 0;
    return {(win ? 2'd1 : 2'd0), 2'(bgp >> (2 * idx))};
  endfunction

  always @(negedge clk) begin : mon
    int rel;
    rel = cyc - t0;
    if (rel == 1) begin
      lvl1 = fifo_level;
      adr1 = vram_adr;
    end
    if (rel == 3) adr3 = vram_adr;
    if (rel == 5) adr5 = vram_adr;
    if (rel == 8) lvl8 = fifo_level;
    if (rel == 15) lvl15 = fifo_level;
    if (rel == r79 + 2) lvlw = fifo_level;
    if (vram_read && vram_adr >= 13'h1C00) win_rd++;
    if (quiet && (vram_read || px_out)) noisy++;
    if (px_out) begin
      if (first_px < 0) first_px = rel;
      last_px = rel;
      if (sb.size() == 0) check("sb_size", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("px", px, e[1:0]);
        check("px_src", px_src, e[3:2]);
      end
      npix++;
      if (npix == 80) r79 = rel;
    end
    if (line_done) begin
      done_rel = rel;
      ndone++;
    end
  end

  task automatic start_line();
    @(posedge clk); #1;
    line_start = 1'b1;
    t0 = cyc;
    first_px = -1; last_px = -1; done_rel = -1;
    npix = 0; ndone = 0; r79 = -100; win_rd = 0;
    lvl1 = -1; lvl8 = -1; lvl15 = -1; lvlw = -1;
    sb.delete();
    for (int x = 0; x < 160; x++) sb.push_back(model(x));
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    while (ndone == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", int'(ndone > 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic line_check(int exp_first);
    check("first_px", first_px, exp_first);
    check("npix", npix, 160);
    check("done_rel", done_rel, last_px + 1);
    check("ndone", ndone, 1);
    check("sb_left", sb.size(), 0);
    check("lvl1", lvl1, 0);
    check("lvl8", lvl8, 8);
    check("lvl15", lvl15, 16);
    check("idle_read", vram_read, 0);
    check("idle_lvl", fifo_level, 0);
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = 8'h00;
    for (int a = 'h1800; a < 'h1C00; a++) mem[a] = 8'h01;
    for (int r = 0; r < 8; r++) begin
      mem[16 + 2 * r] = 8'hFF;
      mem[17 + 2 * r] = 8'h00;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_read", vram_read, 0);
    check("rst_adr", vram_adr, 0);
    check("rst_pxout", px_out, 0);
    check("rst_px", px, 0);
    check("rst_src", px_src, 0);
    check("rst_done", line_done, 0);
    check("rst_lvl", fifo_level, 0);
    reset = 1'b0;

    // Solid colour 1 line.
    start_line();
    wait_done(1000);
    line_check(15);

    for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom);

    scx = 8'd5; scy = 8'd3; ly = 8'd10; bgp = 8'h1B;
    start_line();
    wait_done(1000);
    line_check(20);

    scx = 8'hF3; scy = 8'hFE; ly = 8'd5;
    bg_map = 1'b1; bg_tiles = 1'b0; bgp = 8'h9C;
    start_line();
    wait_done(1000);
    line_check(18);

    scx = 8'd2; bg_ena = 1'b0; bgp = 8'h4E;
    start_line();
    wait_done(1000);
    line_check(17);
    bg_ena = 1'b1;

    // Address checks for tile 0x80 in both addressing modes.
    scx = 8'd0; scy = 8'd3; ly = 8'd10;
    bg_map = 1'b0; bg_tiles = 1'b0; bgp = 8'hE4;
    mem['h1820] = 8'h80;
    start_line();
    wait_done(1000);
    line_check(15);
    check("map_adr_s", adr1, 'h1820);
    check("dat_lo_s", adr3, 'h080A);
    check("dat_hi_s", adr5, 'h080B);

    bg_map = 1'b1; bg_tiles = 1'b1;
    mem['h1C20] = 8'h80;
    start_line();
    wait_done(1000);
    line_check(15);
    check("map_adr_u", adr1, 'h1C20);
    check("dat_lo_u", adr3, 'h080A);
    check("dat_hi_u", adr5, 'h080B);
    bg_map = 1'b0;

    // Restart in the middle of a line.
    scx = 8'd3;
    start_line();
    begin
      int n;
      n = 0;
      while (npix < 40 && n < 500) begin
        @(posedge clk);
        n++;
      end
    end
    check("restart_reach", int'(npix >= 40), 1);
    start_line();
    wait_done(1000);
    line_check(18);

`ifdef PPU_WINDOW_EN
    ly = 8'd0; wy = 8'd0; wx = 8'd87; scx = 8'd4;
    win_ena = 1'b1; win_map = 1'b1; bg_map = 1'b0;
    win_line_m = 0;
    start_line();
    wait_done(1000);
    line_check(19);
    check("win_flush_lvl", lvlw, 0);
    check("win_map_rd", int'(win_rd > 0), 1);

    ly = 8'd1; win_line_m = 1;
    start_line();
    wait_done(1000);
    line_check(19);
    check("win_map_rd2", int'(win_rd > 0), 1);
    win_ena = 1'b0;
`endif

    // Asynchronous reset in cycle 50.
    scx = 8'd0; ly = 8'd0; scy = 8'd0;
    start_line();
    repeat (49) @(posedge clk);
    #3;
    check("pre_rst_busy", int'(vram_read || px_out || fifo_level != 0), 1);
    reset = 1'b1;
    #1;
    check("arst_read", vram_read, 0);
    check("arst_pxout", px_out, 0);
    check("arst_lvl", fifo_level, 0);
    check("arst_adr", vram_adr, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    noisy = 0;
    quiet = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    quiet = 1'b0;
    check("arst_quiet", noisy, 0);

    start_line();
    wait_done(1000);
    line_check(15);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
